// File: rtl/seq_gen_pkg.sv
// Shared constants for the sequence generator: mode codes and control FSM states.
// Used by seq_gen_fsm and seq_next.
package seq_gen_pkg;

    localparam logic [1:0] MODE_UP   = 2'd0;
    localparam logic [1:0] MODE_DOWN = 2'd1;
    localparam logic [1:0] MODE_GRAY = 2'd2;
    localparam logic [1:0] MODE_JOHN = 2'd3;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_RUN  = 2'd1,
        S_DONE = 2'd2
    } state_e;

endpackage

// File: rtl/seq_next.sv
// Combinational next-value and terminal-value generator for seq_gen_fsm.
// Gray mode keeps q in Gray code; Johnson mode shifts raw q without correction.
module seq_next
    import seq_gen_pkg::*;
#(
    parameter int WIDTH = 3
) (
    input  logic [WIDTH-1:0] q_i,
    input  logic [1:0]       mode_i,
    output logic [WIDTH-1:0] next_o,
    output logic [WIDTH-1:0] term_o
);

    logic [WIDTH-1:0] bin;
    logic [WIDTH-1:0] bin_inc;
    logic [WIDTH-1:0] msb_only;

    assign msb_only = {1'b1, {(WIDTH-1){1'b0}}};

    // Gray -> binary, increment, back to Gray
    always_comb begin
        bin = '0;
        bin[WIDTH-1] = q_i[WIDTH-1];
        for (int i = WIDTH - 2; i >= 0; i--) begin
            bin[i] = bin[i+1] ^ q_i[i];
        end
        bin_inc = bin + WIDTH'(1);
    end

    always_comb begin
        next_o = q_i;
        term_o = '1;
        unique case (mode_i)
            MODE_UP: begin
                next_o = q_i + WIDTH'(1);
                term_o = '1;
            end
            MODE_DOWN: begin
                next_o = q_i - WIDTH'(1);
                term_o = '0;
            end
            MODE_GRAY: begin
                next_o = bin_inc ^ (bin_inc >> 1);
                term_o = msb_only;
            end
            MODE_JOHN: begin
                next_o = {q_i[WIDTH-2:0], ~q_i[WIDTH-1]};
                term_o = msb_only;
            end
            default: ;
        endcase
    end

endmodule

// File: rtl/seq_gen_fsm.sv
// Loadable up/down/Gray/Johnson sequence generator with one-shot stop control.
// Define SEQ_DECODE_EN to add the one-hot decode output y.
module seq_gen_fsm
    import seq_gen_pkg::*;
#(
    parameter int WIDTH = 3
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             ld,
    input  logic [WIDTH-1:0] d,
    input  logic             en,
    input  logic [1:0]       mode,
    input  logic             one_shot,
    output logic [WIDTH-1:0] q,
    output logic             tc,
    output logic             busy
`ifdef SEQ_DECODE_EN
    ,
    output logic [(1<<WIDTH)-1:0] y
`endif
);

    state_e           state_q, state_d;
    logic [WIDTH-1:0] seq_q, seq_d;
    logic [WIDTH-1:0] seq_next_w;
    logic [WIDTH-1:0] term_w;

    seq_next #(.WIDTH(WIDTH)) u_next (
        .q_i    (seq_q),
        .mode_i (mode),
        .next_o (seq_next_w),
        .term_o (term_w)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= S_IDLE;
            seq_q   <= '0;
        end else begin
            state_q <= state_d;
            seq_q   <= seq_d;
        end
    end

    // Load overrides everything; DONE is left only by load or reset
    always_comb begin
        state_d = state_q;
        seq_d   = seq_q;
        if (ld) begin
            seq_d   = d;
            state_d = S_RUN;
        end else begin
            unique case (state_q)
                S_IDLE: begin
                    if (en) state_d = S_RUN;
                end
                S_RUN: begin
                    if (en) begin
                        if (one_shot && (seq_q == term_w)) state_d = S_DONE;
                        else seq_d = seq_next_w;
                    end
                end
                S_DONE: ;
                default: state_d = S_IDLE;
            endcase
        end
    end

    always_comb begin
        q    = seq_q;
        tc   = (seq_q == term_w);
        busy = (state_q == S_RUN);
`ifdef SEQ_DECODE_EN
        y    = (1 << WIDTH)'(1) << seq_q;
`endif
    end

endmodule
